block_dispatcher: RTL and testbench
===================================

# block_dispatcher

Parametrised successor to the GPU's block dispatcher. It splits a kernel launch of `thread_count` threads into blocks of `THREADS_PER_BLOCK` threads and hands the blocks to `NUM_CORES` compute cores. Free cores are chosen round-robin, and each core receives the active-thread count of its block so that a partial last block is handled correctly. It raises `done` once every block has retired, and sits between the device control register and the core array.

## Interface
- `NUM_CORES`, default 2: number of cores driven, ≥1.
- `THREADS_PER_BLOCK`, default 4: threads per block; a power of two, ≥1.
- `THREAD_COUNT_WIDTH`, default 8: width of `thread_count`.
- `BLOCK_ID_WIDTH`, default 8: width of each block id; must satisfy ≥ `THREAD_COUNT_WIDTH` − log2(`THREADS_PER_BLOCK`).
- `TC_W`, derived, = $clog2(`THREADS_PER_BLOCK`+1): width of each per-core thread count.

Ports:
- `clk`  in  1  the single clock.
- `reset`  in  1  synchronous, active-high; clears all state.
- `start`  in  1  launch request; level-sampled, acted on only in IDLE or DONE.
- `thread_count`  in  `THREAD_COUNT_WIDTH`  total threads; latched on an accepted `start`.
- `core_done`  in  `NUM_CORES`  per-core block-finished flag; level.
- `core_start`  out  `NUM_CORES`  per-core run enable; held high while the core runs a block.
- `core_reset`  out  `NUM_CORES`  per-core one-cycle reset pulse issued before each block.
- `core_block_id`  out  `NUM_CORES*BLOCK_ID_WIDTH`  packed; core i occupies bits [i*W +: W].
- `core_thread_count`  out  `NUM_CORES*TC_W`  packed; active threads in core i's block.
- `busy`  out  1  high in DISPATCH.
- `done`  out  1  high in DONE.

## Operation
- Global FSM has three states: IDLE, DISPATCH and DONE.
  - IDLE → DISPATCH on `start` when `thread_count` ≠ 0.
  - IDLE → DONE on `start` when `thread_count` = 0.
  - DISPATCH → DONE when `blocks_done` == `total_blocks`.
  - DONE → (IDLE transition rules) on `start`. Otherwise DONE holds.
- On an accepted `start`:
  - latch `thread_count`;
  - compute `total_blocks` = ceil(`thread_count` / `THREADS_PER_BLOCK`) with shift and add, no divider;
  - clear `blocks_dispatched`, `blocks_done` and the round-robin pointer `rr`.
- Each core has its own FSM with three states: FREE, RST and RUN.
  - FREE → RST on assignment.
  - RST → RUN after exactly one cycle.
  - RUN → FREE when `core_done[i]` is sampled high.
- Assignment happens in DISPATCH only.
  - At most one block is assigned per cycle, and only while `blocks_dispatched` < `total_blocks`.
  - The chosen core is the first FREE core at or after `rr`, wrapping modulo `NUM_CORES`.
  - `rr` then moves to chosen+1 (mod `NUM_CORES`).
- On assignment, the chosen core's outputs and the counters update as follows:
  - `core_block_id[i]` ← `blocks_dispatched`;
  - `core_thread_count[i]` ← min(`THREADS_PER_BLOCK`, `thread_count` − `blocks_dispatched`*`THREADS_PER_BLOCK`);
  - `blocks_dispatched` increments.
- `core_reset[i]` is high only in RST. `core_start[i]` is high only in RUN.
- On RUN → FREE, `blocks_done` increments. The freed core can be reassigned no earlier than the next cycle.
- Ignored inputs:
  - `core_done[i]` while core i is FREE or RST;
  - `start` in DISPATCH.
- In DONE, all per-core FSMs are FREE. `core_block_id` and `core_thread_count` keep their last values.
- Counters are `THREAD_COUNT_WIDTH`+1 bits wide, so `total_blocks` at maximum `thread_count` does not wrap.

## Timing
- Reset values: all outputs 0; global FSM in IDLE; every core FREE; all counters and `rr` 0.
- `reset` asserted mid-operation forces the reset values on the next edge. Cores running at that moment see `core_start` drop. No `done` is produced.
- All outputs are registered.
- Let `start` be sampled at edge N.
  - `busy` goes high after edge N.
  - The first assignment is at edge N+1: `core_reset[0]` is high during cycle N+1.
  - `core_start[0]` is high from edge N+2.
  - Core 1 is assigned at edge N+2, and so on, one core per edge.
- If `core_done[i]` is sampled at edge M:
  - `core_start[i]` drops after M;
  - core i may be reassigned at edge M+1 at the earliest.
- If the last retirement is at edge M, `done` rises and `busy` falls after edge M+1.
- Zero-thread launch: `done` is high after edge N.
- Restart from DONE: `done` drops after the edge at which `start` is sampled.

## Test plan
- NUM_CORES=2, TPB=4, `thread_count`=8, each core returns `core_done` 5 cycles after `core_start`:
  - block ids 0 and 1 go to cores 0 and 1, `core_thread_count`=4 on each;
  - `done` rises 1 cycle after the second retirement.
- `thread_count`=10, same configuration:
  - 3 blocks; block 2 is assigned to the first core to free up, with `core_thread_count`=2;
  - `done` after 3 retirements.
- NUM_CORES=4, core 0 finishes much faster than the others, 9 blocks:
  - assignment order follows round-robin among FREE cores;
  - no core receives a block while in RST or RUN;
  - each id 0..8 is issued exactly once.
- `thread_count`=0:
  - `done` high 1 cycle after `start`;
  - `core_reset` and `core_start` never assert.
- `reset` asserted while two cores are in RUN:
  - all outputs read 0 the next cycle;
  - a following `start` with `thread_count`=4 dispatches block 0 to core 0.
- Spurious stimulus:
  - `core_done` held high on a FREE core, and `start` re-asserted during DISPATCH, are both ignored;
  - `blocks_done` is unchanged and the launch completes normally.

Source files
------------

// File: rtl/block_dispatcher.sv
// -----------------------------------------------------------------------------
// block_dispatcher
//
// Splits a kernel launch of thread_count threads into blocks of
// THREADS_PER_BLOCK threads and hands them to NUM_CORES compute cores.
// Free cores are picked round-robin. Each core gets its block id and the number
// of threads that are active in that block, so a partial last block is handled
// correctly. done is raised once every block has retired.
//
// Ports
//   clk               : single clock
//   reset             : synchronous, active-high; clears all state
//   start             : launch request, acted on only in IDLE or DONE
//   thread_count      : total threads, latched when start is accepted
//   core_done         : per-core block-finished flag (level)
//   core_start        : per-core run enable, high while the core runs a block
//   core_reset        : per-core one-cycle reset pulse ahead of each block
//   core_block_id     : packed block ids, core i at [i*BLOCK_ID_WIDTH +: BLOCK_ID_WIDTH]
//   core_thread_count : packed active-thread counts, core i at [i*TC_W +: TC_W]
//   busy              : high while dispatching
//   done              : high once the launch has completed
// -----------------------------------------------------------------------------
module block_dispatcher #(
   parameter int NUM_CORES          = 2,
   parameter int THREADS_PER_BLOCK  = 4,
   parameter int THREAD_COUNT_WIDTH = 8,
   parameter int BLOCK_ID_WIDTH     = 8,
   parameter int TC_W               = $clog2(THREADS_PER_BLOCK + 1)
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                start,
   input  logic [THREAD_COUNT_WIDTH-1:0]       thread_count,
   input  logic [NUM_CORES-1:0]                core_done,
   output logic [NUM_CORES-1:0]                core_start,
   output logic [NUM_CORES-1:0]                core_reset,
   output logic [NUM_CORES*BLOCK_ID_WIDTH-1:0] core_block_id,
   output logic [NUM_CORES*TC_W-1:0]           core_thread_count,
   output logic                                busy,
   output logic                                done
);

   localparam int LOG2_TPB = $clog2(THREADS_PER_BLOCK);
   // One extra bit so the block count at the largest thread_count cannot wrap.
   localparam int CW       = THREAD_COUNT_WIDTH + 1;
   // Wide enough for thread_count + TPB - 1 and for blocks_dispatched * TPB.
   localparam int RW       = CW + LOG2_TPB;
   localparam int RRW      = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

   typedef enum logic [1:0] {G_IDLE, G_DISPATCH, G_DONE} gstate_t;
   typedef enum logic [1:0] {C_FREE, C_RST, C_RUN}       cstate_t;

   gstate_t                             r_gstate;
   cstate_t                             r_cstate [NUM_CORES];
   logic [THREAD_COUNT_WIDTH-1:0]       r_tc;
   logic [CW-1:0]                       r_total;
   logic [CW-1:0]                       r_dispatched;
   logic [CW-1:0]                       r_done_cnt;
   logic [RRW-1:0]                      r_rr;
   logic [NUM_CORES-1:0]                r_core_start;
   logic [NUM_CORES-1:0]                r_core_reset;
   logic [NUM_CORES*BLOCK_ID_WIDTH-1:0] r_block_id;
   logic [NUM_CORES*TC_W-1:0]           r_core_tc;
   logic                                r_busy;
   logic                                r_done;

   logic [NUM_CORES-1:0] w_retire;
   logic [CW-1:0]        w_retire_cnt;
   logic                 w_found;
   logic [RRW-1:0]       w_sel;
   logic [RRW-1:0]       w_rr_next;
   logic                 w_assign;
   logic                 w_accept;
   logic [CW-1:0]        w_total_next;
   logic [RW-1:0]        w_base;
   logic [RW-1:0]        w_rem;
   logic [TC_W-1:0]      w_blk_tc;

   // Several cores may retire in the same cycle; all of them must be counted.
   always_comb begin
      w_retire_cnt = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         w_retire[i]  = (r_cstate[i] == C_RUN) && core_done[i];
         w_retire_cnt = w_retire_cnt + {{(CW-1){1'b0}}, w_retire[i]};
      end
   end

   // Round-robin pick: the FREE core with the smallest distance (mod NUM_CORES)
   // from the pointer. Looping over fixed core indices keeps all selects constant.
   always_comb begin
      int d;
      int best;
      d       = 0;
      best    = NUM_CORES;
      w_found = 1'b0;
      w_sel   = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         d = i - int'(r_rr);
         if (d < 0) d = d + NUM_CORES;
         if ((r_cstate[i] == C_FREE) && (d < best)) begin
            best    = d;
            w_found = 1'b1;
            w_sel   = RRW'(i);
         end
      end
   end

   assign w_rr_next = (w_sel == RRW'(NUM_CORES - 1)) ? '0 : w_sel + RRW'(1);

   assign w_accept = start && ((r_gstate == G_IDLE) || (r_gstate == G_DONE));
   assign w_assign = (r_gstate == G_DISPATCH) && (r_dispatched < r_total) && w_found;

   // ceil(thread_count / TPB) as (thread_count + TPB - 1) >> log2(TPB).
   assign w_total_next = CW'((RW'(thread_count) + RW'(THREADS_PER_BLOCK - 1)) >> LOG2_TPB);

   // Threads left from the next block onward; never zero while a block remains.
   assign w_base   = RW'(r_dispatched) << LOG2_TPB;
   assign w_rem    = RW'(r_tc) - w_base;
   assign w_blk_tc = (w_rem >= RW'(THREADS_PER_BLOCK)) ? TC_W'(THREADS_PER_BLOCK) : TC_W'(w_rem);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_gstate     <= G_IDLE;
         r_tc         <= '0;
         r_total      <= '0;
         r_dispatched <= '0;
         r_done_cnt   <= '0;
         r_rr         <= '0;
         r_core_start <= '0;
         r_core_reset <= '0;
         r_block_id   <= '0;
         r_core_tc    <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         for (int i = 0; i < NUM_CORES; i++) r_cstate[i] <= C_FREE;
      end else begin
         // Global launch control
         case (r_gstate)
            G_IDLE, G_DONE: begin
               if (w_accept) begin
                  r_tc         <= thread_count;
                  r_total      <= w_total_next;
                  r_dispatched <= '0;
                  r_done_cnt   <= '0;
                  r_rr         <= '0;
                  if (thread_count != '0) begin
                     r_gstate <= G_DISPATCH;
                     r_busy   <= 1'b1;
                     r_done   <= 1'b0;
                  end else begin
                     r_gstate <= G_DONE;
                     r_busy   <= 1'b0;
                     r_done   <= 1'b1;
                  end
               end
            end
            G_DISPATCH: begin
               if (r_done_cnt == r_total) begin
                  r_gstate <= G_DONE;
                  r_busy   <= 1'b0;
                  r_done   <= 1'b1;
               end else begin
                  r_done_cnt <= r_done_cnt + w_retire_cnt;
                  if (w_assign) begin
                     r_dispatched <= r_dispatched + CW'(1);
                     r_rr         <= w_rr_next;
                  end
               end
            end
            default: begin
               r_gstate <= G_IDLE;
               r_busy   <= 1'b0;
               r_done   <= 1'b0;
            end
         endcase

         // Per-core block lifecycle
         for (int i = 0; i < NUM_CORES; i++) begin
            case (r_cstate[i])
               C_FREE: begin
                  if (w_assign && (w_sel == RRW'(i))) begin
                     r_cstate[i]                            <= C_RST;
                     r_core_reset[i]                        <= 1'b1;
                     r_block_id[i*BLOCK_ID_WIDTH +: BLOCK_ID_WIDTH] <= BLOCK_ID_WIDTH'(r_dispatched);
                     r_core_tc[i*TC_W +: TC_W]              <= w_blk_tc;
                  end
               end
               C_RST: begin
                  r_cstate[i]     <= C_RUN;
                  r_core_reset[i] <= 1'b0;
                  r_core_start[i] <= 1'b1;
               end
               C_RUN: begin
                  if (core_done[i]) begin
                     r_cstate[i]     <= C_FREE;
                     r_core_start[i] <= 1'b0;
                  end
               end
               default: begin
                  r_cstate[i]     <= C_FREE;
                  r_core_reset[i] <= 1'b0;
                  r_core_start[i] <= 1'b0;
               end
            endcase
         end
      end
   end

   assign core_start        = r_core_start;
   assign core_reset        = r_core_reset;
   assign core_block_id     = r_block_id;
   assign core_thread_count = r_core_tc;
   assign busy              = r_busy;
   assign done              = r_done;

endmodule

// File: tb/tb_block_dispatcher.sv
// -----------------------------------------------------------------------------
// tb_block_dispatcher
//
// Two dispatcher instances: a 2-core one for the table of launches, reset and
// spurious-input sequences, and a 4-core one for round-robin with one fast core.
// A small responder per core raises core_done a set number of cycles after
// core_start; a monitor logs every block hand-off and checks it hit a free core.
// -----------------------------------------------------------------------------
module tb_block_dispatcher;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   typedef struct {
      int core;
      int id;
      int tc;
   } asg_t;

   typedef struct {
      int tc;
      int lat;
      int blocks;
      int cyc;
      int last_tc;
   } vec_t;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // ---------------- 2-core instance ----------------
   logic        start2 = 1'b0;
   logic [7:0]  tc2    = '0;
   logic [1:0]  resp2  = '0;
   logic [1:0]  spur2  = '0;
   logic [1:0]  cdone2;
   logic [1:0]  cstart2, creset2;
   logic [15:0] cbid2;
   logic [5:0]  ctc2;
   logic        busy2, done2;
   int          lat2 [2] = '{5, 5};
   int          cnt2 [2] = '{0, 0};
   asg_t        log2q [$];
   logic [1:0]  prev2 = '0;

   assign cdone2 = resp2 | spur2;

   block_dispatcher #(.NUM_CORES(2), .THREADS_PER_BLOCK(4),
                      .THREAD_COUNT_WIDTH(8), .BLOCK_ID_WIDTH(8)) dut2 (
      .clk(clk), .reset(rst), .start(start2), .thread_count(tc2),
      .core_done(cdone2), .core_start(cstart2), .core_reset(creset2),
      .core_block_id(cbid2), .core_thread_count(ctc2),
      .busy(busy2), .done(done2));

   // ---------------- 4-core instance ----------------
   logic        start4 = 1'b0;
   logic [7:0]  tc4    = '0;
   logic [3:0]  resp4  = '0;
   logic [3:0]  cstart4, creset4;
   logic [31:0] cbid4;
   logic [11:0] ctc4;
   logic        busy4, done4;
   int          lat4 [4] = '{1, 12, 12, 12};
   int          cnt4 [4] = '{0, 0, 0, 0};
   asg_t        log4q [$];
   logic [3:0]  prev4 = '0;

   block_dispatcher #(.NUM_CORES(4), .THREADS_PER_BLOCK(4),
                      .THREAD_COUNT_WIDTH(8), .BLOCK_ID_WIDTH(8)) dut4 (
      .clk(clk), .reset(rst), .start(start4), .thread_count(tc4),
      .core_done(resp4), .core_start(cstart4), .core_reset(creset4),
      .core_block_id(cbid4), .core_thread_count(ctc4),
      .busy(busy4), .done(done4));

   // Core models: count cycles of core_start, then pulse core_done.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (cstart2[i] && !resp2[i]) begin
            cnt2[i]++;
            if (cnt2[i] >= lat2[i]) resp2[i] = 1'b1;
         end else if (!cstart2[i]) begin
            resp2[i] = 1'b0;
            cnt2[i]  = 0;
         end
      end
      for (int i = 0; i < 4; i++) begin
         if (cstart4[i] && !resp4[i]) begin
            cnt4[i]++;
            if (cnt4[i] >= lat4[i]) resp4[i] = 1'b1;
         end else if (!cstart4[i]) begin
            resp4[i] = 1'b0;
            cnt4[i]  = 0;
         end
      end
   end

   // Hand-off monitors: a core_reset pulse is one assignment; the core must
   // have been neither in reset nor running on the previous cycle.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (creset2[i]) begin
            chk($sformatf("c2_assign_to_free_core%0d", i), int'(prev2[i]), 0);
            chk($sformatf("c2_rst_run_excl_core%0d", i), int'(cstart2[i]), 0);
            log2q.push_back('{i, int'(cbid2[i*8 +: 8]), int'(ctc2[i*3 +: 3])});
         end
         prev2[i] = creset2[i] | cstart2[i];
      end
      for (int i = 0; i < 4; i++) begin
         if (creset4[i]) begin
            chk($sformatf("c4_assign_to_free_core%0d", i), int'(prev4[i]), 0);
            chk($sformatf("c4_rst_run_excl_core%0d", i), int'(cstart4[i]), 0);
            log4q.push_back('{i, int'(cbid4[i*8 +: 8]), int'(ctc4[i*3 +: 3])});
         end
         prev4[i] = creset4[i] | cstart4[i];
      end
   end

   // One launch on the 2-core instance; k = edges after the start edge until done.
   task automatic launch2(input int tc_in, input int lat, output int k);
      lat2[0] = lat;
      lat2[1] = lat;
      log2q.delete();
      @(negedge clk);
      start2 = 1'b1;
      tc2    = 8'(tc_in);
      @(posedge clk);
      @(negedge clk);
      start2 = 1'b0;
      chk("busy_after_start", int'(busy2), int'(tc_in != 0));
      chk("done_after_start", int'(done2), int'(tc_in == 0));
      k = 0;
      while (!done2 && k < 3000) begin
         @(posedge clk);
         k++;
         @(negedge clk);
      end
      chk("busy_low_at_done", int'(busy2), 0);
   endtask

   vec_t vecs [7];
   int   k;
   int   exp_core4 [9] = '{0, 1, 2, 3, 0, 0, 0, 0, 1};

   initial begin
      vecs[0] = '{8,   5, 2,  9,  4};
      vecs[1] = '{10,  5, 3,  15, 2};
      vecs[2] = '{4,   5, 1,  8,  4};
      vecs[3] = '{1,   3, 1,  6,  1};
      vecs[4] = '{0,   5, 0,  0,  0};
      vecs[5] = '{6,   2, 2,  6,  2};
      vecs[6] = '{255, 1, 64, 98, 3};

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_core_start2", int'(cstart2), 0);
      chk("rst_core_reset2", int'(creset2), 0);
      chk("rst_block_id2", int'(cbid2), 0);
      chk("rst_thread_cnt2", int'(ctc2), 0);
      chk("rst_busy2", int'(busy2), 0);
      chk("rst_done2", int'(done2), 0);
      chk("rst_core_start4", int'(cstart4), 0);
      chk("rst_busy4", int'(busy4), 0);
      chk("rst_done4", int'(done4), 0);

      // Table of launches with uniform core latency: blocks alternate 0,1,0,1...
      for (int v = 0; v < 7; v++) begin
         launch2(vecs[v].tc, vecs[v].lat, k);
         chk($sformatf("v%0d_cycles_to_done", v), k, vecs[v].cyc);
         chk($sformatf("v%0d_block_count", v), log2q.size(), vecs[v].blocks);
         for (int j = 0; j < log2q.size(); j++) begin
            chk($sformatf("v%0d_b%0d_core", v, j), log2q[j].core, j % 2);
            chk($sformatf("v%0d_b%0d_id", v, j), log2q[j].id, j);
            chk($sformatf("v%0d_b%0d_tc", v, j), log2q[j].tc,
                (j == vecs[v].blocks - 1) ? vecs[v].last_tc : 4);
         end
         repeat (2) @(negedge clk);
      end

      // Reset while both cores run
      lat2[0] = 20;
      lat2[1] = 20;
      @(negedge clk);
      start2 = 1'b1;
      tc2    = 8'd8;
      @(negedge clk);
      start2 = 1'b0;
      for (int w = 0; w < 50 && cstart2 != 2'b11; w++) @(negedge clk);
      chk("midrst_both_running", int'(cstart2), 3);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_core_start", int'(cstart2), 0);
      chk("midrst_core_reset", int'(creset2), 0);
      chk("midrst_block_id", int'(cbid2), 0);
      chk("midrst_thread_cnt", int'(ctc2), 0);
      chk("midrst_busy", int'(busy2), 0);
      chk("midrst_done", int'(done2), 0);
      launch2(4, 5, k);
      chk("postrst_cycles", k, 8);
      chk("postrst_blocks", log2q.size(), 1);
      if (log2q.size() > 0) begin
         chk("postrst_core", log2q[0].core, 0);
         chk("postrst_id", log2q[0].id, 0);
         chk("postrst_tc", log2q[0].tc, 4);
      end
      repeat (2) @(negedge clk);

      // Spurious inputs: core_done held on idle core 1, zero-length start
      // pulses during dispatch. Launch must finish as if neither happened.
      spur2   = 2'b10;
      lat2[0] = 5;
      lat2[1] = 5;
      log2q.delete();
      @(negedge clk);
      start2 = 1'b1;
      tc2    = 8'd4;
      @(posedge clk);
      @(negedge clk);
      start2 = 1'b0;
      k = 0;
      while (!done2 && k < 3000) begin
         @(posedge clk);
         k++;
         @(negedge clk);
         start2 = (k == 2 || k == 3);
         tc2    = (k == 2 || k == 3) ? 8'd0 : 8'd4;
      end
      start2 = 1'b0;
      chk("spur_cycles", k, 8);
      chk("spur_blocks", log2q.size(), 1);
      chk("spur_no_core1_start", int'(cstart2[1]), 0);
      spur2 = 2'b00;
      repeat (2) @(negedge clk);

      // 4 cores, core 0 fast: order follows round-robin among free cores.
      log4q.delete();
      @(negedge clk);
      start4 = 1'b1;
      tc4    = 8'd36;
      @(posedge clk);
      @(negedge clk);
      start4 = 1'b0;
      chk("c4_busy_after_start", int'(busy4), 1);
      k = 0;
      while (!done4 && k < 3000) begin
         @(posedge clk);
         k++;
         @(negedge clk);
      end
      chk("c4_cycles_to_done", k, 30);
      chk("c4_block_count", log4q.size(), 9);
      for (int j = 0; j < log4q.size() && j < 9; j++) begin
         chk($sformatf("c4_b%0d_core", j), log4q[j].core, exp_core4[j]);
         chk($sformatf("c4_b%0d_id", j), log4q[j].id, j);
         chk($sformatf("c4_b%0d_tc", j), log4q[j].tc, 4);
      end
      chk("c4_idle_at_done", int'(cstart4 | creset4), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
